temp_bcd_scan: RTL and testbench

- Display back-end that sits directly downstream of the DS18B20 controller.
- Takes the 20-bit unsigned temperature magnitude (units of 0.001 °C) and its sign bit.
- Converts the magnitude to six BCD digits with a sequential double-dabble engine, one bit per clock.
- Drives an 8-digit multiplexed 7-segment display: one-hot digit select, active-low segments, decimal point after the °C units digit.

---
 rtl/temp_bcd_scan.sv | 192 +++++++++++++++++++
 tb/tb_temp_bcd_scan.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/temp_bcd_scan.sv
// Temperature display back-end: serial double-dabble conversion of the m°C magnitude
// into six BCD digits, plus an 8-digit multiplexed active-low 7-segment scanner.
module temp_bcd_scan #(
   parameter int SCAN_DIV = 5000,
   parameter int BIN_W    = 20,
   parameter int BCD_MAX  = 999999
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [BIN_W-1:0] data_in,
   input  logic             sign_in,
   output logic [7:0]       dig_sel,
   output logic [6:0]       seg,
   output logic             seg_dp,
   output logic             busy,
   output logic             conv_done
);

   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam logic [BIN_W-1:0] SAT_VAL  = BIN_W'(BCD_MAX);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SHIFT  = 2'd2,
      COMMIT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             do_capture, do_load, do_shift, do_commit;

   logic [BIN_W-1:0] shadow_data_q;
   logic             shadow_sign_q;
   logic [BIN_W-1:0] bin_sr_q;
   logic [23:0]      bcd_sr_q;
   logic [23:0]      bcd_adj;
   logic [4:0]       bit_cnt_q;
   logic [BIN_W-1:0] sat_data;

   logic [3:0]       dig_q [6];
   logic             sign_q;

   logic [PRE_W-1:0] pre_q;
   logic [2:0]       scan_idx_q;
   logic [6:0]       seg_d;

   // ---------------- conversion FSM ----------------
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      do_capture = 1'b0;
      do_load    = 1'b0;
      do_shift   = 1'b0;
      do_commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if ({sign_in, data_in} != {shadow_sign_q, shadow_data_q}) begin
               do_capture = 1'b1;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            do_load = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            do_shift = 1'b1;
            if (bit_cnt_q == 5'(BIN_W - 1)) state_d = COMMIT;
         end
         COMMIT: begin
            do_commit = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- double-dabble datapath ----------------
   assign sat_data = (shadow_data_q > SAT_VAL) ? SAT_VAL : shadow_data_q;

   always_comb begin
      bcd_adj = bcd_sr_q;
      for (int i = 0; i < 6; i++) begin
         if (bcd_sr_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         shadow_data_q <= '0;
         shadow_sign_q <= 1'b0;
         bin_sr_q      <= '0;
         bcd_sr_q      <= '0;
         bit_cnt_q     <= '0;
      end else begin
         if (do_capture) begin
            shadow_data_q <= data_in;
            shadow_sign_q <= sign_in;
         end
         if (do_load) begin
            bin_sr_q  <= sat_data;
            bcd_sr_q  <= '0;
            bit_cnt_q <= '0;
         end
         if (do_shift) begin
            {bcd_sr_q, bin_sr_q} <= {bcd_adj[22:0], bin_sr_q, 1'b0};
            bit_cnt_q            <= bit_cnt_q + 5'd1;
         end
      end
   end

   // Committed digits change only here, so the display never sees a partial result.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < 6; i++) dig_q[i] <= 4'd0;
         sign_q    <= 1'b0;
         busy      <= 1'b0;
         conv_done <= 1'b0;
      end else begin
         if (do_commit) begin
            for (int i = 0; i < 6; i++) dig_q[i] <= bcd_sr_q[4*i +: 4];
            sign_q <= shadow_sign_q;
         end
         busy      <= (state_q != IDLE);
         conv_done <= do_commit;
      end
   end

   // ---------------- display scan ----------------
   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'b0000001;
         4'd1:    g = 7'b1001111;
         4'd2:    g = 7'b0010010;
         4'd3:    g = 7'b0000110;
         4'd4:    g = 7'b1001100;
         4'd5:    g = 7'b0100100;
         4'd6:    g = 7'b0100000;
         4'd7:    g = 7'b0001111;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0000100;
         default: g = 7'h7F;
      endcase
      return g;
   endfunction

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pre_q      <= '0;
         scan_idx_q <= 3'd0;
      end else if (pre_q == PRE_LAST) begin
         pre_q      <= '0;
         scan_idx_q <= scan_idx_q + 3'd1;
      end else begin
         pre_q <= pre_q + PRE_W'(1);
      end
   end

   always_comb begin
      seg_d = 7'h7F;
      case (scan_idx_q)
         3'd0: seg_d = glyph(dig_q[0]);
         3'd1: seg_d = glyph(dig_q[1]);
         3'd2: seg_d = glyph(dig_q[2]);
         3'd3: seg_d = glyph(dig_q[3]);
         3'd4: seg_d = glyph(dig_q[4]);
         3'd5: seg_d = glyph(dig_q[5]);
         3'd6: seg_d = sign_q ? 7'b1111110 : 7'h7F;
         default: seg_d = 7'h7F;
      endcase
   end

   // Decimal point sits after digit 3, the whole-degree units position.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dig_sel <= 8'h00;
         seg     <= 7'h7F;
         seg_dp  <= 1'b1;
      end else begin
         dig_sel <= 8'b1 << scan_idx_q;
         seg     <= seg_d;
         seg_dp  <= (scan_idx_q != 3'd3);
      end
   end

endmodule

// File: tb/tb_temp_bcd_scan.sv
// Bench for temp_bcd_scan: a cycle-indexed arithmetic model checked every cycle,
// plus directed conversions with hand-computed literal expectations.
module tb_temp_bcd_scan;

   localparam int SD = 4;

   logic        sys_clk;
   logic        sys_rst_n;
   logic [19:0] data_in;
   logic        sign_in;
   logic [7:0]  dig_sel;
   logic [6:0]  seg;
   logic        seg_dp;
   logic        busy;
   logic        conv_done;

   int checks   = 0;
   int failures = 0;

   temp_bcd_scan #(.SCAN_DIV(SD)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .data_in   (data_in),
      .sign_in   (sign_in),
      .dig_sel   (dig_sel),
      .seg       (seg),
      .seg_dp    (seg_dp),
      .busy      (busy),
      .conv_done (conv_done)
   );

   // ---------------- clock ----------------
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [6:0] glyph_tab [10];
   initial begin
      glyph_tab[0] = 7'b0000001; glyph_tab[1] = 7'b1001111; glyph_tab[2] = 7'b0010010;
      glyph_tab[3] = 7'b0000110; glyph_tab[4] = 7'b1001100; glyph_tab[5] = 7'b0100100;
      glyph_tab[6] = 7'b0100000; glyph_tab[7] = 7'b0001111; glyph_tab[8] = 7'b0000000;
      glyph_tab[9] = 7'b0000100;
   end

   function automatic logic [6:0] exp_seg(input int k, input int val, input logic sgn);
      int p;
      if (k < 6) begin
         p = 1;
         for (int i = 0; i < k; i++) p = p * 10;
         return glyph_tab[(val / p) % 10];
      end
      if (k == 6) return sgn ? 7'b1111110 : 7'h7F;
      return 7'h7F;
   endfunction

   // Edge-numbered schedule: an accepted change at edge c commits at c+22,
   // and the next change can be accepted from edge c+23.
   int         cyc, ready_at, commit_at, cap_cyc, done_cyc;
   int         pend_val, com_val, disp_val;
   logic       pend_sign, com_sign, disp_sign, pending;
   logic [20:0] shadow;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cyc <= 0; ready_at <= 1; commit_at <= -1; cap_cyc <= -100; done_cyc <= -1;
         pend_val <= 0; com_val <= 0; disp_val <= 0;
         pend_sign <= 1'b0; com_sign <= 1'b0; disp_sign <= 1'b0; pending <= 1'b0;
         shadow <= '0;
      end else begin
         cyc       <= cyc + 1;
         disp_val  <= com_val;
         disp_sign <= com_sign;
         if (pending && (cyc + 1 == commit_at)) begin
            com_val  <= pend_val;
            com_sign <= pend_sign;
            pending  <= 1'b0;
            done_cyc <= cyc + 1;
         end
         if ((cyc + 1 >= ready_at) && ({sign_in, data_in} != shadow)) begin
            shadow    <= {sign_in, data_in};
            pending   <= 1'b1;
            pend_val  <= (int'(data_in) > 999999) ? 999999 : int'(data_in);
            pend_sign <= sign_in;
            commit_at <= cyc + 23;
            ready_at  <= cyc + 24;
            cap_cyc   <= cyc + 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int cmp_idx;
   always @(negedge sys_clk) begin
      if (!sys_rst_n || cyc == 0) begin
         check("rst_dig_sel", 32'(dig_sel), 32'h00);
         check("rst_seg", 32'(seg), 32'h7F);
         check("rst_dp", 32'(seg_dp), 32'd1);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_done", 32'(conv_done), 32'd0);
      end else begin
         cmp_idx = ((cyc - 1) / SD) % 8;
         check("dig_sel", 32'(dig_sel), 32'(8'd1 << cmp_idx));
         check("seg", 32'(seg), 32'(exp_seg(cmp_idx, disp_val, disp_sign)));
         check("seg_dp", 32'(seg_dp), (cmp_idx == 3) ? 32'd0 : 32'd1);
         check("busy", 32'(busy), ((cyc >= cap_cyc + 1) && (cyc <= cap_cyc + 22)) ? 32'd1 : 32'd0);
         check("conv_done", 32'(conv_done), (cyc == done_cyc) ? 32'd1 : 32'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apply(input logic [19:0] d, input logic s);
      @(posedge sys_clk);
      #2;
      data_in = d;
      sign_in = s;
   endtask

   // Counts negedges after the capture edge until conv_done is seen.
   task automatic wait_done(input string name, input int exp_n);
      int n;
      n = 0;
      @(negedge sys_clk);
      while (!conv_done && n < 60) begin
         @(negedge sys_clk);
         n++;
      end
      check(name, n, exp_n);
   endtask

   task automatic wait_digit(input int k);
      int n;
      n = 0;
      while (dig_sel != (8'd1 << k) && n < 40) begin
         @(negedge sys_clk);
         n++;
      end
      check("digit_reached", 32'(dig_sel), 32'(8'd1 << k));
   endtask

   task automatic run_conv(input string name, input logic [19:0] d, input logic s);
      apply(d, s);
      @(posedge sys_clk);
      wait_done(name, 22);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      sys_rst_n = 1'b0;
      data_in   = '0;
      sign_in   = 1'b0;
      repeat (3) @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;

      // Idle scan with zero input: full cycle of all eight digits.
      repeat (5) @(posedge sys_clk);
      @(negedge sys_clk);
      check("dig_sel_edge5", 32'(dig_sel), 32'h02);
      repeat (36) @(posedge sys_clk);

      run_conv("lat_25062", 20'd25062, 1'b0);
      @(negedge sys_clk);
      wait_digit(1);
      check("lit_25062_d1", 32'(seg), 32'(7'b0100000));
      wait_digit(4);
      check("lit_25062_d4", 32'(seg), 32'(7'b0010010));

      run_conv("lat_10125", 20'd10125, 1'b1);
      @(negedge sys_clk);
      wait_digit(6);
      check("lit_neg_d6", 32'(seg), 32'(7'b1111110));
      wait_digit(0);
      check("lit_10125_d0", 32'(seg), 32'(7'b0100100));

      run_conv("lat_sat", 20'hFFFFF, 1'b0);
      @(negedge sys_clk);
      wait_digit(0);
      check("lit_sat_d0", 32'(seg), 32'(7'b0000100));
      wait_digit(3);
      check("lit_sat_dp", 32'(seg_dp), 32'd0);
      wait_digit(5);
      check("lit_sat_d5", 32'(seg), 32'(7'b0000100));

      // Change arrives mid-conversion; it is picked up after the single idle cycle.
      apply(20'd1000, 1'b0);
      @(posedge sys_clk);
      repeat (5) @(posedge sys_clk);
      #2 data_in = 20'd2000;
      wait_done("lat_1000_first", 17);
      @(negedge sys_clk);
      check("gap_busy_low", 32'(busy), 32'd0);
      @(negedge sys_clk);
      check("gap_busy_high", 32'(busy), 32'd1);
      wait_done("lat_2000_second", 20);
      check("model_val_2000", com_val, 2000);
      @(negedge sys_clk);
      wait_digit(3);
      check("lit_2000_d3", 32'(seg), 32'(7'b0010010));

      // Reset in the middle of a conversion.
      apply(20'd5000, 1'b0);
      @(posedge sys_clk);
      repeat (8) @(posedge sys_clk);
      #2 sys_rst_n = 1'b0;
      @(negedge sys_clk);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_dig_sel", 32'(dig_sel), 32'h00);
      repeat (2) @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;
      wait_done("lat_after_rst", 23);
      @(negedge sys_clk);
      wait_digit(3);
      check("lit_5000_d3", 32'(seg), 32'(7'b0100100));

      repeat (40) @(posedge sys_clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
